// File: rtl/usb_pkg.sv
// usb_pkg: shared line-state/FSM types and constants for the FS USB receive path.
// Line-state encoding is {dp, dn} so the synchronizer output casts directly.
package usb_pkg;

    localparam int STUFF_LIMIT = 6;
    localparam int OVERSAMPLE  = 4;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } rx_state_t;

    // SE1 is electrically illegal; treat it like SE0.
    function automatic logic is_se(input line_t ls);
        return (ls == LS_SE0) || (ls == LS_SE1);
    endfunction

endpackage

// File: rtl/usb_line_sync.sv
// usb_line_sync: 2-FF pad synchronizer producing the FS line state.
// Build option USB_RX_GLITCH_FILTER_EN adds a 3-sample majority filter (+1 cycle).
module usb_line_sync
    import usb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  pad_dp,
    input  logic  pad_dn,
    output line_t line_state
);

    logic [1:0] r_meta;
    logic [1:0] r_sync;

    // Reset to J so the receiver never sees a false SE0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 2'b10;
            r_sync <= 2'b10;
        end else begin
            r_meta <= {pad_dp, pad_dn};
            r_sync <= r_meta;
        end
    end

`ifdef USB_RX_GLITCH_FILTER_EN
    logic [1:0] r_h1;
    logic [1:0] r_h2;
    logic [1:0] w_maj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h1 <= 2'b10;
            r_h2 <= 2'b10;
        end else begin
            r_h1 <= r_sync;
            r_h2 <= r_h1;
        end
    end

    assign w_maj = (r_sync & r_h1) | (r_sync & r_h2) | (r_h1 & r_h2);
    assign line_state = line_t'(w_maj);
`else
    assign line_state = line_t'(r_sync);
`endif

endmodule

// File: rtl/usb_fs_rx_phy.sv
// usb_fs_rx_phy: FS USB receive front end - DPLL, NRZI decode, unstuff, framing.
// Build option USB_RX_GLITCH_FILTER_EN enables the line glitch filter.
module usb_fs_rx_phy
    import usb_pkg::*;
#(
    parameter int IDLE_ABORT_BITS = 8,
    parameter int SYNC_MIN_ZEROS  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_dp,
    input  logic pad_dn,
    output logic rx_active,
    output logic rx_sop,
    output logic rx_bit,
    output logic rx_valid,
    output logic rx_eop,
    output logic rx_err
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
    localparam int JW = $clog2(IDLE_ABORT_BITS + 1);
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(2);

    line_t         w_line;
    line_t         r_line_prev;
    line_t         r_prev_jk;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase;
    logic          w_samp;
    logic          w_se;
    logic          w_jk;
    logic          w_dbit;
    logic          w_stuffed;
    logic          w_sync_ok;
    logic [OW-1:0] r_ones;
    logic [ZW-1:0] r_zeros;
    logic [JW-1:0] r_jcnt;

    rx_state_t     r_state;
    rx_state_t     w_state_nx;

    logic          w_sop;
    logic          w_valid;
    logic          w_eop;
    logic          w_err;
    logic          w_active;

    logic          r_active;
    logic          r_sop;
    logic          r_bit;
    logic          r_valid;
    logic          r_eop;
    logic          r_err;

    usb_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .pad_dp     (pad_dp),
        .pad_dn     (pad_dn),
        .line_state (w_line)
    );

    // Phase is 0 in the cycle a transition is seen, so phase 2 is mid-bit.
    assign w_phase   = (w_line != r_line_prev) ? '0 : r_phase;
    assign w_samp    = (w_phase == SAMPLE_PHASE);
    assign w_se      = is_se(w_line);
    assign w_jk      = w_samp && !w_se;
    assign w_dbit    = (w_line == r_prev_jk);
    assign w_stuffed = (r_ones == OW'(STUFF_LIMIT));
    assign w_sync_ok = (r_zeros >= ZW'(SYNC_MIN_ZEROS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_prev <= LS_J;
            r_prev_jk   <= LS_J;
            r_phase     <= '0;
            r_ones      <= '0;
            r_zeros     <= '0;
            r_jcnt      <= '0;
        end else begin
            r_line_prev <= w_line;
            r_phase     <= w_phase + 1'b1;
            if (w_jk) begin
                r_prev_jk <= w_line;
            end

            if (r_state == ST_SYNC || r_state == ST_DATA) begin
                if (w_jk) begin
                    if (r_state == ST_DATA && w_stuffed) begin
                        r_ones <= '0;
                    end else if (w_dbit) begin
                        r_ones <= r_ones + 1'b1;
                    end else begin
                        r_ones <= '0;
                    end
                end
            end else begin
                r_ones <= '0;
            end

            // The K that leaves IDLE is already the first SYNC zero.
            if (r_state == ST_IDLE) begin
                r_zeros <= ZW'(1);
            end else if (r_state == ST_SYNC && w_jk && !w_dbit) begin
                if (r_zeros != ZW'(SYNC_MIN_ZEROS)) begin
                    r_zeros <= r_zeros + 1'b1;
                end
            end

            if (r_state == ST_ABORT) begin
                if (w_samp) begin
                    if (w_line == LS_J) begin
                        r_jcnt <= r_jcnt + 1'b1;
                    end else begin
                        r_jcnt <= '0;
                    end
                end
            end else begin
                r_jcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_samp && w_line == LS_K) begin
                    w_state_nx = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_samp && w_se) begin
                    w_state_nx = ST_IDLE;
                end else if (w_jk && w_dbit) begin
                    w_state_nx = w_sync_ok ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_samp && w_se) begin
                    w_state_nx = ST_EOP;
                end else if (w_jk && w_stuffed && w_dbit) begin
                    w_state_nx = ST_ABORT;
                end
            end
            ST_EOP: begin
                if (w_samp && w_line == LS_J) begin
                    w_state_nx = ST_IDLE;
                end else if (w_samp && w_line == LS_K) begin
                    w_state_nx = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (w_samp && w_line == LS_J &&
                    r_jcnt == JW'(IDLE_ABORT_BITS - 1)) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sop   = 1'b0;
        w_valid = 1'b0;
        w_eop   = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            ST_SYNC: begin
                w_sop = w_jk && w_dbit && w_sync_ok;
            end
            ST_DATA: begin
                w_valid = w_jk && !w_stuffed;
                w_err   = w_jk && w_stuffed && w_dbit;
            end
            ST_EOP: begin
                w_eop = w_samp && (w_line == LS_J);
                w_err = w_samp && (w_line == LS_K);
            end
            default: begin
            end
        endcase
        w_active = (w_state_nx == ST_DATA) || (w_state_nx == ST_EOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_sop    <= 1'b0;
            r_bit    <= 1'b0;
            r_valid  <= 1'b0;
            r_eop    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_active <= w_active;
            r_sop    <= w_sop;
            r_valid  <= w_valid;
            r_eop    <= w_eop;
            r_err    <= w_err;
            if (w_valid) begin
                r_bit <= w_dbit;
            end
        end
    end

    assign rx_active = r_active;
    assign rx_sop    = r_sop;
    assign rx_bit    = r_bit;
    assign rx_valid  = r_valid;
    assign rx_eop    = r_eop;
    assign rx_err    = r_err;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// tb_usb_fs_rx_phy: directed packets through usb_fs_rx_phy with an NRZI/stuffing
// encoder in the bench and event counters checked after each packet.
module tb_usb_fs_rx_phy;

    logic clk = 1'b0;
    logic rst;
    logic pad_dp;
    logic pad_dn;
    logic rx_active;
    logic rx_sop;
    logic rx_bit;
    logic rx_valid;
    logic rx_eop;
    logic rx_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sop = 0;
    int n_eop = 0;
    int n_err = 0;
    int n_val = 0;
    int n_excl = 0;
    logic [31:0] rx_data = '0;

    bit cur = 1'b1;
    bit alt_mode = 1'b0;
    int bit_idx = 0;

    usb_fs_rx_phy #(
        .IDLE_ABORT_BITS (8),
        .SYNC_MIN_ZEROS  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_dp    (pad_dp),
        .pad_dn    (pad_dn),
        .rx_active (rx_active),
        .rx_sop    (rx_sop),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .rx_eop    (rx_eop),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_sop) n_sop++;
            if (rx_eop) n_eop++;
            if (rx_err) n_err++;
            if (rx_valid) begin
                if (n_val < 32) rx_data[n_val] = rx_bit;
                n_val++;
            end
            if (int'(rx_sop) + int'(rx_valid) + int'(rx_eop) + int'(rx_err) > 1)
                n_excl++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_sop = 0;
        n_eop = 0;
        n_err = 0;
        n_val = 0;
        rx_data = '0;
    endtask

    task automatic drive(input logic dp, input logic dn, input int n);
        pad_dp = dp;
        pad_dn = dn;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line_bit(input logic dp, input logic dn);
        int n;
        n = alt_mode ? (((bit_idx % 2) == 1) ? 5 : 3) : 4;
        bit_idx++;
        drive(dp, dn, n);
    endtask

    task automatic send_lvl(input bit lvl);
        line_bit(lvl, ~lvl);
    endtask

    task automatic idle(input int n);
        cur = 1'b1;
        repeat (n) send_lvl(1'b1);
    endtask

    // bits[] is SYNC followed by payload, LSB first, NRZI-encoded from J.
    task automatic send(input logic [31:0] bits, input int nbits,
                        input bit stuff, input bit eop);
        int ones;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            if (bits[i]) begin
                ones++;
            end else begin
                cur = ~cur;
                ones = 0;
            end
            send_lvl(cur);
            if (stuff && ones == 6) begin
                cur = ~cur;
                ones = 0;
                send_lvl(cur);
            end
        end
        if (eop) begin
            line_bit(1'b0, 1'b0);
            line_bit(1'b0, 1'b0);
            idle(1);
        end
    endtask

    task automatic check_pkt(input string tag, input int sop, input int nval,
                             input logic [31:0] data, input int eop, input int err);
        check({tag, ".sop"},   n_sop, sop);
        check({tag, ".nval"},  n_val, nval);
        check({tag, ".data"},  rx_data, data);
        check({tag, ".eop"},   n_eop, eop);
        check({tag, ".err"},   n_err, err);
        check({tag, ".active"}, {31'd0, rx_active}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 4);
        check("reset.outs",
              {26'd0, rx_active, rx_sop, rx_bit, rx_valid, rx_eop, rx_err}, 32'd0);
        rst = 1'b0;
        idle(8);

        clr();
        send({16'h0, 8'hA5, 8'h80}, 16, 1'b1, 1'b1);
        idle(4);
        check_pkt("a5", 1, 8, 32'hA5, 1, 0);

        clr();
        send({16'hFFFF, 8'h80}, 24, 1'b1, 1'b1);
        idle(4);
        check_pkt("ffff", 1, 16, 32'hFFFF, 1, 0);

        clr();
        alt_mode = 1'b1;
        bit_idx = 0;
        send({8'h0, 16'h3CA5, 8'h80}, 24, 1'b1, 1'b1);
        idle(4);
        alt_mode = 1'b0;
        check_pkt("jitter", 1, 16, 32'h3CA5, 1, 0);

        clr();
        send({29'd0, 3'b100}, 3, 1'b1, 1'b0);
        idle(10);
        check_pkt("shortsync", 0, 0, 32'h0, 0, 0);

        clr();
        send({20'd0, 8'h5A, 4'h8}, 12, 1'b1, 1'b1);
        idle(4);
        check_pkt("minsync", 1, 8, 32'h5A, 1, 0);

        clr();
        send({18'd0, 6'h3F, 8'h80}, 14, 1'b0, 1'b0);
        idle(2);
        check_pkt("stufferr", 1, 5, 32'h1F, 0, 1);

        clr();
        idle(2);
        send({16'h0, 8'hA5, 8'h80}, 16, 1'b1, 1'b1);
        idle(10);
        check_pkt("abort", 0, 0, 32'h0, 0, 0);

        clr();
        send({16'h0, 8'h3C, 8'h80}, 16, 1'b1, 1'b1);
        idle(4);
        check_pkt("recover", 1, 8, 32'h3C, 1, 0);

        clr();
        send({20'd0, 4'b1101, 8'h80}, 12, 1'b1, 1'b0);
        check("rst.active_before", {31'd0, rx_active}, 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1);
        check("rst.outs",
              {26'd0, rx_active, rx_sop, rx_bit, rx_valid, rx_eop, rx_err}, 32'd0);
        rst = 1'b0;
        idle(10);
        check("rst.eop", n_eop, 0);
        check("rst.err", n_err, 0);

        clr();
        send({8'h0, 16'hC3A5, 8'h80}, 24, 1'b1, 1'b1);
        idle(4);
        check_pkt("afterrst", 1, 16, 32'hC3A5, 1, 0);

        check("exclusive", n_excl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
